// File: rtl/id_decode_pipe.sv
// id_decode_pipe: RV32I decode stage with registered ID/EX, load-use interlock and N-port forwarding.
// Define ID_PERF_CNT_EN to add the perf_issue_o / perf_bubble_o counters.
`ifndef AluOpBus
`define AluOpBus 7:0
`endif
`ifndef AluSelBus
`define AluSelBus 7:0
`endif
`ifndef Inst_NOP
`define Inst_NOP    8'd0
`define Inst_LUI    8'd1
`define Inst_AUIPC  8'd2
`define Inst_JAL    8'd3
`define Inst_JALR   8'd4
`define Inst_BRANCH 8'd5
`define Inst_LOAD   8'd6
`define Inst_STORE  8'd7
`define Inst_OPIMM  8'd8
`define Inst_OP     8'd9
`endif
`ifndef NOP
`define NOP   8'd0
`define LUI   8'd1
`define AUIPC 8'd2
`define JAL   8'd3
`define JALR  8'd4
`define BEQ   8'd5
`define BNE   8'd6
`define BLT   8'd7
`define BGE   8'd8
`define BLTU  8'd9
`define BGEU  8'd10
`define LB    8'd11
`define LH    8'd12
`define LW    8'd13
`define LBU   8'd14
`define LHU   8'd15
`define SB    8'd16
`define SH    8'd17
`define SW    8'd18
`define ADDI  8'd19
`define SLTI  8'd20
`define SLTIU 8'd21
`define XORI  8'd22
`define ORI   8'd23
`define ANDI  8'd24
`define SLLI  8'd25
`define SRLI  8'd26
`define SRAI  8'd27
`define ADD   8'd28
`define SUB   8'd29
`define SLL   8'd30
`define SLT   8'd31
`define SLTU  8'd32
`define XOR   8'd33
`define SRL   8'd34
`define SRA   8'd35
`define OR    8'd36
`define AND   8'd37
`endif

module id_decode_pipe #(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter int RA_W      = 5,
  parameter int FWD_PORTS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PC_W-1:0]           pc_i,
  input  logic [31:0]               inst_i,
  input  logic                      flush_i,
  input  logic [FWD_PORTS-1:0]      fwd_wreg_i,
  input  logic [FWD_PORTS*RA_W-1:0] fwd_wd_i,
  input  logic [FWD_PORTS*XLEN-1:0] fwd_wdata_i,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  output logic [RA_W-1:0]           reg1_addr_o,
  output logic [RA_W-1:0]           reg2_addr_o,
  input  logic [XLEN-1:0]           reg1_data_i,
  input  logic [XLEN-1:0]           reg2_data_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_W-1:0]           pc_o,
  output logic [`AluOpBus]          aluop_o,
  output logic [`AluSelBus]         alusel_o,
  output logic [XLEN-1:0]           imm_o,
  output logic [XLEN-1:0]           reg1_o,
  output logic [XLEN-1:0]           reg2_o,
  output logic                      wreg_o,
  output logic [RA_W-1:0]           wd_o,
  output logic                      illegal_o
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]               perf_issue_o,
  output logic [31:0]               perf_bubble_o
`endif
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       alt;
  logic [RA_W-1:0] rd, rs1, rs2;

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];
  assign alt = inst_i[30];
  assign rd  = RA_W'(inst_i[11:7]);
  assign rs1 = RA_W'(inst_i[19:15]);
  assign rs2 = RA_W'(inst_i[24:20]);

  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                  inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                  inst_i[20], inst_i[30:21], 1'b0};

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_ld, is_st, is_opi, is_op;

  assign is_lui   = opc == 7'h37;
  assign is_auipc = opc == 7'h17;
  assign is_jal   = opc == 7'h6f;
  assign is_jalr  = opc == 7'h67;
  assign is_br    = opc == 7'h63;
  assign is_ld    = opc == 7'h03;
  assign is_st    = opc == 7'h23;
  assign is_opi   = opc == 7'h13;
  assign is_op    = opc == 7'h33;

  logic [`AluOpBus]  d_aluop;
  logic [`AluSelBus] d_alusel;
  logic [XLEN-1:0]   d_imm;
  logic              d_r1, d_r2, d_wreg, d_ill;
  logic [RA_W-1:0]   d_wd;
  logic              d_ld;

  always_comb begin
    d_aluop  = `Inst_NOP;
    d_alusel = `NOP;
    d_imm    = '0;
    d_r1     = 1'b0;
    d_r2     = 1'b0;
    d_wreg   = 1'b0;
    d_ill    = 1'b0;
    unique case (1'b1)
      is_lui: begin
        d_aluop  = `Inst_LUI;
        d_alusel = `LUI;
        d_imm    = XLEN'(imm_u);
        d_wreg   = 1'b1;
      end
      is_auipc: begin
        d_aluop  = `Inst_AUIPC;
        d_alusel = `AUIPC;
        d_imm    = XLEN'(imm_u);
        d_wreg   = 1'b1;
      end
      is_jal: begin
        d_aluop  = `Inst_JAL;
        d_alusel = `JAL;
        d_imm    = XLEN'(imm_j);
        d_wreg   = 1'b1;
      end
      is_jalr: begin
        d_aluop  = `Inst_JALR;
        d_alusel = `JALR;
        d_imm    = XLEN'(imm_i);
        d_r1     = 1'b1;
        d_wreg   = 1'b1;
        d_ill    = f3 != 3'b000;
      end
      is_br: begin
        d_aluop = `Inst_BRANCH;
        d_imm   = XLEN'(imm_b);
        d_r1    = 1'b1;
        d_r2    = 1'b1;
        unique case (f3)
          3'b000:  d_alusel = `BEQ;
          3'b001:  d_alusel = `BNE;
          3'b100:  d_alusel = `BLT;
          3'b101:  d_alusel = `BGE;
          3'b110:  d_alusel = `BLTU;
          3'b111:  d_alusel = `BGEU;
          default: d_ill = 1'b1;
        endcase
      end
      is_ld: begin
        d_aluop = `Inst_LOAD;
        d_imm   = XLEN'(imm_i);
        d_r1    = 1'b1;
        d_wreg  = 1'b1;
        unique case (f3)
          3'b000:  d_alusel = `LB;
          3'b001:  d_alusel = `LH;
          3'b010:  d_alusel = `LW;
          3'b100:  d_alusel = `LBU;
          3'b101:  d_alusel = `LHU;
          default: d_ill = 1'b1;
        endcase
      end
      is_st: begin
        d_aluop = `Inst_STORE;
        d_imm   = XLEN'(imm_s);
        d_r1    = 1'b1;
        d_r2    = 1'b1;
        unique case (f3)
          3'b000:  d_alusel = `SB;
          3'b001:  d_alusel = `SH;
          3'b010:  d_alusel = `SW;
          default: d_ill = 1'b1;
        endcase
      end
      is_opi: begin
        d_aluop = `Inst_OPIMM;
        d_imm   = XLEN'(imm_i);
        d_r1    = 1'b1;
        d_wreg  = 1'b1;
        unique case (f3)
          3'b000: d_alusel = `ADDI;
          3'b010: d_alusel = `SLTI;
          3'b011: d_alusel = `SLTIU;
          3'b100: d_alusel = `XORI;
          3'b110: d_alusel = `ORI;
          3'b111: d_alusel = `ANDI;
          3'b001: begin
            d_alusel = `SLLI;
            d_imm    = XLEN'(inst_i[24:20]);
          end
          default: begin
            d_alusel = alt ? `SRAI : `SRLI;
            d_imm    = XLEN'(inst_i[24:20]);
          end
        endcase
      end
      is_op: begin
        d_aluop = `Inst_OP;
        d_r1    = 1'b1;
        d_r2    = 1'b1;
        d_wreg  = 1'b1;
        unique case (f3)
          3'b000:  d_alusel = alt ? `SUB : `ADD;
          3'b001:  d_alusel = `SLL;
          3'b010:  d_alusel = `SLT;
          3'b011:  d_alusel = `SLTU;
          3'b100:  d_alusel = `XOR;
          3'b101:  d_alusel = alt ? `SRA : `SRL;
          3'b110:  d_alusel = `OR;
          default: d_alusel = `AND;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
    // undecodable words must not read, write or look like a load
    if (d_ill) begin
      d_aluop  = `Inst_NOP;
      d_alusel = `NOP;
      d_imm    = '0;
      d_r1     = 1'b0;
      d_r2     = 1'b0;
      d_wreg   = 1'b0;
    end
  end

  assign d_wd = d_wreg ? rd : '0;
  assign d_ld = d_aluop == `Inst_LOAD;

  assign reg1_read_o = d_r1;
  assign reg2_read_o = d_r2;
  assign reg1_addr_o = d_r1 ? rs1 : '0;
  assign reg2_addr_o = d_r2 ? rs2 : '0;

  logic [XLEN-1:0] op1, op2;

  // walk oldest to youngest so the lowest index wins
  always_comb begin
    op1 = reg1_data_i;
    op2 = reg2_data_i;
    for (int k = FWD_PORTS - 1; k >= 0; k--) begin
      if (fwd_wreg_i[k] && fwd_wd_i[k*RA_W +: RA_W] == rs1)
        op1 = fwd_wdata_i[k*XLEN +: XLEN];
      if (fwd_wreg_i[k] && fwd_wd_i[k*RA_W +: RA_W] == rs2)
        op2 = fwd_wdata_i[k*XLEN +: XLEN];
    end
    if (!d_r1 || rs1 == '0) op1 = '0;
    if (!d_r2 || rs2 == '0) op2 = '0;
  end

  logic ld_q;
  logic hz;
  logic take;

  assign hz = out_valid && ld_q && (wd_o != '0) &&
              ((d_r1 && rs1 == wd_o) || (d_r2 && rs2 == wd_o));

  assign in_ready = flush_i || (!hz && (!out_valid || out_ready));
  assign take     = in_valid && in_ready && !flush_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      pc_o      <= '0;
      aluop_o   <= `Inst_NOP;
      alusel_o  <= `NOP;
      imm_o     <= '0;
      reg1_o    <= '0;
      reg2_o    <= '0;
      wreg_o    <= 1'b0;
      wd_o      <= '0;
      illegal_o <= 1'b0;
      ld_q      <= 1'b0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
      ld_q      <= 1'b0;
    end else if (take) begin
      out_valid <= 1'b1;
      pc_o      <= pc_i;
      aluop_o   <= d_aluop;
      alusel_o  <= d_alusel;
      imm_o     <= d_imm;
      reg1_o    <= op1;
      reg2_o    <= op2;
      wreg_o    <= d_wreg;
      wd_o      <= d_wd;
      illegal_o <= d_ill;
      ld_q      <= d_ld;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      ld_q      <= 1'b0;
    end
  end

`ifdef ID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_issue_o  <= '0;
      perf_bubble_o <= '0;
    end else begin
      if (take)
        perf_issue_o <= perf_issue_o + 32'd1;
      if (hz && out_ready)
        perf_bubble_o <= perf_bubble_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_decode_pipe.md
Name: id_decode_pipe

Overview:
Parametrised successor to the decode stage of the RV32I pipeline. Decodes one instruction per cycle, reads the regfile, and resolves operands through N forwarding sources. Adds what the current decode lacks: a registered ID/EX output with a valid/ready handshake, a real load-use interlock (one-bubble insertion), flush, x0 forwarding suppression, SRLI/SRAI discrimination and an illegal-instruction flag. Sits between IF/ID and ex.

Parameters:
XLEN, 32, data/operand width
PC_W, 32, pc width
RA_W, 5, register address width
FWD_PORTS, 2, forwarding sources; index 0 = youngest (EX), highest priority

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-low (asserted when 0)
in_valid  in  1  IF/ID holds an instruction
in_ready  out  1  decode accepts the instruction this cycle
pc_i  in  PC_W  instruction pc
inst_i  in  32  instruction word
flush_i  in  1  kill current input and ID/EX contents (branch redirect)
fwd_wreg_i  in  FWD_PORTS  per-source write enable
fwd_wd_i  in  FWD_PORTS*RA_W  per-source destination, packed, port k at [k*RA_W +: RA_W]
fwd_wdata_i  in  FWD_PORTS*XLEN  per-source result, packed likewise
reg1_read_o / reg2_read_o  out  1  regfile read enables (combinational)
reg1_addr_o / reg2_addr_o  out  RA_W  rs1 / rs2 (combinational)
reg1_data_i / reg2_data_i  in  XLEN  regfile read data
out_valid  out  1  ID/EX register holds a valid op
out_ready  in  1  ex accepts the op
pc_o  out  PC_W  registered pc
aluop_o  out  `AluOpBus  registered op class
alusel_o  out  `AluSelBus  registered sub-op
imm_o  out  XLEN  registered immediate
reg1_o / reg2_o  out  XLEN  registered resolved operands
wreg_o  out  1  registered write enable
wd_o  out  RA_W  registered rd
illegal_o  out  1  registered: op was an undecodable instruction

Behaviour:
- Reset (rst==0 at edge): out_valid=0, all registered outputs 0, aluop `Inst_NOP, alusel `NOP, internal load flag 0.
- Decode table identical in coverage to the existing decode (LUI, AUIPC, JAL, JALR, branch, load, store, OP-IMM, OP). Additionally: funct3=101 OP-IMM selects `SRAI when inst[30]=1, else `SRLI; OP uses inst[30] for SUB/SRA. Unknown opcode or unlisted funct3 -> NOP fields, wreg=0, illegal=1.
- Operand resolution per read port: if addr==0 -> 0; else the lowest index k with fwd_wreg_i[k] && fwd_wd_i[k]==addr -> fwd_wdata_i[k]; else regfile data. Ports not read -> 0.
- Hazard: hz = out_valid && held op is load && wd_o!=0 && ((reg1_read && rs1==wd_o) || (reg2_read && rs2==wd_o)).
- in_ready = !hz && (!out_valid || out_ready); when flush_i=1, in_ready=1 and the input is discarded.
- Register update priority: flush_i -> out_valid<=0. Else if in_valid&&in_ready -> load decoded op, out_valid<=1. Else if out_valid&&out_ready -> out_valid<=0 (bubble; covers load-use). Else hold.
- Load-use costs exactly one bubble: after the load leaves ID/EX, the dependent op resolves via the MEM forwarding port.
- Latency: 1 cycle input-to-out_valid. Held outputs are stable while out_valid&&!out_ready.
- Reset asserted mid-stall or flush: reset wins.

Optional Feature:
ID_PERF_CNT_EN: when defined, adds outputs perf_issue_o[31:0] (count of accepted instructions) and perf_bubble_o[31:0] (cycles in which hz=1 and out_ready=1). Both reset to 0, wrap at 2^32, and are not cleared by flush. When undefined, the ports and the logic are absent.

Test Plan:
- ADDI x1,x0,5 then ADD x2,x1,x1 with fwd port0 {1,x1,5} -> second op reg1_o=reg2_o=5, latency 1 cycle each.
- LW x3,0(x0) then ADDI x4,x3,1 -> in_ready=0 one cycle, one bubble (out_valid=0), then ADDI issues with reg1_o = port1 data 0xDEADBEEF.
- Both fwd ports target x5 (port0=7, port1=9), regfile=3 -> reg1_o=7; target x0 with data 0x55 -> reg1_o=0.
- SRAI x6,x6,2 (inst[30]=1) -> alusel `SRAI; opcode 0x7F -> illegal_o=1, wreg_o=0.
- out_ready=0 for 3 cycles with a valid op -> outputs stable, in_ready=0; flush_i pulse -> out_valid=0 next cycle.
- rst=0 during load-use stall -> all outputs 0; with ID_PERF_CNT_EN, 10 issued ops and 2 load-use cases -> perf_issue_o=10, perf_bubble_o=2.
